tick_timebase: RTL
==================

# tick_timebase

Parametrised timebase for the watch datapath. It divides the board clock into a one-cycle tick enable at a configurable rate, with a fast mode for time-setting and a square-wave output for LEDs or blinking digits. It also holds a modulo tick counter with a wrap carry, so instances can be cascaded without extra logic. It replaces the fixed 1 Hz toggle divider and feeds the seconds/minutes/hours counters and the display blinker.

## Interface
Parameters:
- CLK_HZ, 100_000_000, input clock frequency in Hz
- TICK_HZ, 1, normal tick rate in Hz; DIV = CLK_HZ/TICK_HZ (integer), DIV >= 2
- FAST_DIV, 60, fast-mode speed-up; LF = DIV/FAST_DIV (integer), LF >= 2
- MOD, 60, modulus of tick counter, MOD >= 2
- Derived: CNT_W = $clog2(DIV), MOD_W = $clog2(MOD); elaboration error if any constraint is violated

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous reset, active-high
- en  in  1  count enable; low = freeze all state
- clr  in  1  synchronous phase restart
- fast  in  1  select period LF instead of DIV
- tick  out  1  one-cycle pulse at each period wrap
- sq  out  1  square wave, period equal to the active period L
- ticks  out  MOD_W  tick count, 0..MOD-1
- carry  out  1  one-cycle pulse when ticks wraps MOD-1 -> 0

## Operation
- Active period L = fast ? LF : DIV; half point H = L/2 (floor).
- Internal counter cnt, CNT_W bits, counts 0..L-1.
- Priority per edge: rst > clr > en.
- rst: cnt=0, tick=0, sq=0, ticks=0, carry=0.
- clr (rst low): same values as rst; en is ignored that cycle.
- en low (rst, clr low): cnt, sq and ticks hold; tick=0, carry=0.
- en high, cnt >= L-1 (wrap): cnt<=0, tick<=1, sq<=1.
  - ticks <= (ticks==MOD-1) ? 0 : ticks+1.
  - carry <= (ticks==MOD-1).
- en high, cnt == H-1 (no wrap): cnt<=cnt+1, sq<=0, tick<=0, carry<=0.
- en high, otherwise: cnt<=cnt+1, tick<=0, carry<=0, sq holds.
- Wrap uses >= so a fast toggle while cnt >= LF-1 wraps on the next enabled edge. No overshoot, no counter overflow.
- H-1 < L-1 for all L >= 2, so midpoint and wrap never coincide.
- fast may change on any cycle. The transitional period is irregular, with length <= max(DIV, LF). All later periods are exact.
- ticks never exceeds MOD-1. carry asserts only together with tick.

## Timing
- All outputs are registered; no combinational path from input to output.
- From the first enabled edge after rst/clr, with en held high, tick is first asserted after exactly L edges, then every L cycles.
- tick width is exactly 1 cycle when en is continuous. If en drops the cycle after a wrap, tick still clears.
- sq is high for H cycles (cnt 0..H-1 after a wrap) and low for L-H cycles; 50 % duty when L is even.
- sq stays 0 until the first wrap after reset.
- carry is coincident with the tick that moves ticks MOD-1 -> 0; one pulse every MOD*L cycles.
- en low for k cycles stretches the current period by exactly k cycles; phase is otherwise preserved.
- rst or clr mid-period discards the partial period; counting restarts from cnt=0 on the next enabled edge.

## Test plan
Bench parameters: CLK_HZ=20, TICK_HZ=2, FAST_DIV=5, MOD=3, so DIV=10 and LF=2.
- Reset and free-run: rst 2 cycles, then en=1. First tick 10 edges after release, then every 10. sq high 5, low 5. ticks 0,1,2,0. carry pulses with every 3rd tick (period 30).
- Fast mode: fast=1 from reset. tick every 2 cycles; sq alternates 1,0. carry every 6 cycles.
- Mid-period mode switch: set fast=1 when cnt=7. Wrap on the next edge (tick); then regular 2-cycle period.
- Enable gating: drop en for 4 cycles at cnt=3. Next tick arrives 14 cycles after the previous one. sq and ticks hold, and tick stays 0, while en is low.
- clr and rst precedence: assert clr at cnt=8, ticks=2. Next edge: all outputs 0, no tick/carry. Assert rst and clr together with en=1: reset values. The following tick is 10 edges after release.
- Max-width check: default parameters. After 100_000_000 enabled edges: exactly 1 tick, ticks=1, sq=1; no counter overflow observed.

Source files
------------

// File: rtl/tick_timebase.sv
// Programmable tick divider with a fast mode, a square-wave output and a cascadable
// modulo tick counter that pulses carry on wrap.
module tick_timebase #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int TICK_HZ  = 1,
    parameter int FAST_DIV = 60,
    parameter int MOD      = 60
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     fast,
    output logic                     tick,
    output logic                     sq,
    output logic [$clog2(MOD)-1:0]   ticks,
    output logic                     carry
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int LF    = DIV / FAST_DIV;
    localparam int CNT_W = $clog2(DIV);
    localparam int MOD_W = $clog2(MOD);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] DIV_HM1  = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] LF_LAST  = CNT_W'(LF - 1);
    localparam logic [CNT_W-1:0] LF_HM1   = CNT_W'(LF / 2 - 1);
    localparam logic [MOD_W-1:0] MOD_LAST = MOD_W'(MOD - 1);

    if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
        $error("tick_timebase: CLK_HZ/TICK_HZ must be an integer >= 2");
    end
    if (FAST_DIV < 1 || (DIV % FAST_DIV) != 0 || LF < 2) begin : g_bad_lf
        $error("tick_timebase: DIV/FAST_DIV must be an integer >= 2");
    end
    if (MOD < 2) begin : g_bad_mod
        $error("tick_timebase: MOD must be >= 2");
    end

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;
    logic [CNT_W-1:0] half_m1;

    always_comb begin
        last    = fast ? LF_LAST : DIV_LAST;
        half_m1 = fast ? LF_HM1  : DIV_HM1;
    end

    // Wrap on >= so a switch to the shorter period never overshoots.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt   <= '0;
            tick  <= 1'b0;
            sq    <= 1'b0;
            ticks <= '0;
            carry <= 1'b0;
        end else if (en) begin
            tick  <= 1'b0;
            carry <= 1'b0;
            if (cnt >= last) begin
                cnt   <= '0;
                tick  <= 1'b1;
                sq    <= 1'b1;
                ticks <= (ticks == MOD_LAST) ? '0 : ticks + MOD_W'(1);
                carry <= (ticks == MOD_LAST);
            end else begin
                cnt <= cnt + CNT_W'(1);
                if (cnt == half_m1) begin
                    sq <= 1'b0;
                end
            end
        end else begin
            tick  <= 1'b0;
            carry <= 1'b0;
        end
    end

endmodule
